alu_exec_ctrl: RTL

//  Multi-cycle execute controller placed directly upstream of the 8-bit alu.
//  - Accepts one command per handshake and reads operands from an internal 8x8 register file.
//  - Drives the alu's a/b/s inputs and captures its out/z/n/c/v.
//  - Writes the result back to the register file and latches the flags into a flag register.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_regfile.sv | 43 ++++
 rtl/alu_exec_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the alu execute controller
// and its register file.
package alu_pkg;

  localparam int NREGS = 8;
  localparam int DW    = 8;
  localparam int AW    = $clog2(NREGS);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DW register file: two registered read ports, one write port,
// and a combinational debug read port that sees the pre-write value.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      if (we) begin
        mem[wa] <= wdata;
      end
      // Read data holds between reads so the alu operands stay put.
      if (rd_en) begin
        rdata1 <= mem[ra1];
        rdata2 <= mem[ra2];
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller feeding an external 8-bit alu; one
// command per four cycles, result and flags written back in WB.
//
//   state  | meaning
//   IDLE   | cmd_ready=1, latch command on handshake
//   READ   | registered read of rs1/rs2 into alu operand regs
//   EXEC   | alu inputs stable, capture alu_out and flags
//   WB     | write R[rd], result and flag registers
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          cmd_imm_en,
  input  logic [DW-1:0] cmd_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_s,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_c,
  input  logic          alu_v,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c,
  output logic          flag_v,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t state_q, state_d;

  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs1_q, rs2_q;
  logic          imm_en_q;
  logic [DW-1:0] imm_q;

  logic [2:0]    alu_s_q;
  logic          b_imm_sel_q;
  logic [DW-1:0] b_imm_q;

  logic [DW-1:0] res_q;
  logic          hz_q, hn_q, hc_q, hv_q;

  logic          rf_rd_en, rf_we, exec_cap;
  logic [DW-1:0] rf_rd1, rf_rd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rf_rd_en  = 1'b0;
    exec_cap  = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_READ;
      end
      S_READ: begin
        rf_rd_en = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        exec_cap = 1'b1;
        state_d  = S_WB;
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_en_q    <= 1'b0;
      imm_q       <= '0;
      alu_s_q     <= '0;
      b_imm_sel_q <= 1'b0;
      b_imm_q     <= '0;
      res_q       <= '0;
      hz_q        <= 1'b0;
      hn_q        <= 1'b0;
      hc_q        <= 1'b0;
      hv_q        <= 1'b0;
      result      <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        op_q     <= cmd_op;
        rd_q     <= cmd_rd;
        rs1_q    <= cmd_rs1;
        rs2_q    <= cmd_rs2;
        imm_en_q <= cmd_imm_en;
        imm_q    <= cmd_imm;
      end
      // Operand-b select and alu_s load alongside the regfile read so all
      // three alu inputs change on the same edge and then hold.
      if (rf_rd_en) begin
        alu_s_q     <= op_q;
        b_imm_sel_q <= imm_en_q;
        b_imm_q     <= imm_q;
      end
      if (exec_cap) begin
        res_q <= alu_out;
        hz_q  <= alu_z;
        hn_q  <= alu_n;
        hc_q  <= alu_c;
        hv_q  <= alu_v;
      end
      if (rf_we) begin
        result <= res_q;
        flag_z <= hz_q;
        flag_n <= hn_q;
        flag_c <= hc_q;
        flag_v <= hv_q;
      end
      done <= rf_we;
    end
  end

  alu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rf_rd_en),
    .ra1      (rs1_q),
    .ra2      (rs2_q),
    .rdata1   (rf_rd1),
    .rdata2   (rf_rd2),
    .we       (rf_we),
    .wa       (rd_q),
    .wdata    (res_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_a = rf_rd1;
  assign alu_b = b_imm_sel_q ? b_imm_q : rf_rd2;
  assign alu_s = alu_s_q;

endmodule
